// File: rtl/entrada_decimal_pkg.sv
// Shared definitions for the two-digit decimal entry block: FSM encoding and value limits.
package entrada_decimal_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_UNI = 2'd1,
        DONE     = 2'd2,
        ERR      = 2'd3
    } estado_t;

    localparam logic [6:0] MAX_VALOR  = 7'd31;
    localparam logic [3:0] MAX_DIGITO = 4'd9;

endpackage

// File: rtl/entrada_decimal_detector_borda.sv
// ENTER conditioning: two-flop synchronizer, optional debounce (ENTRADA_DEBOUNCE_EN)
// and falling-edge detector producing a one-cycle press pulse.
module detector_borda #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic CLOCK_50,
    input  logic RST_N,
    input  logic raw_in,
    output logic press
);

    logic       sync1_q, sync2_q;
    logic       prev_q;
    logic       arm_q, arm_d;
    logic [1:0] fill_q;
    logic       nivel;

    // Presses are armed only once a genuine released level has been synchronized,
    // so a button held through reset release never produces a press.
    always_comb begin
        arm_d = arm_q | (fill_q[1] & sync2_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            arm_q   <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            prev_q  <= nivel;
            arm_q   <= arm_d;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

`ifdef ENTRADA_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // Counts consecutive cycles disagreeing with the accepted level; any agreement reloads it.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign nivel = stable_q;
`else
    localparam int DEB_UNUSED = DEB_CYCLES;

    assign nivel = sync2_q;
`endif

    assign press = arm_q & prev_q & ~nivel;

endmodule

// File: rtl/entrada_decimal.sv
// Two-digit decimal entry (tens then units) producing a 0..31 binary value.
// Optional ENTER debounce is enabled with ENTRADA_DEBOUNCE_EN.
module entrada_decimal
    import entrada_decimal_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [3:0] DIG,
    input  logic       ENTER,
    input  logic       CLEAR,
    output logic [4:0] VALOR,
    output logic       VALID,
    output logic       ERRO,
    output logic [3:0] DEZ,
    output logic [3:0] UNI
);

    logic       press;
    estado_t    estado_q, estado_d;
    logic [4:0] valor_q, valor_d;
    logic [3:0] dez_q, dez_d;
    logic [3:0] uni_q, uni_d;
    logic [6:0] soma;

    detector_borda #(.DEB_CYCLES(DEB_CYCLES)) u_detector (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .raw_in   (ENTER),
        .press    (press)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            estado_q <= IDLE;
            valor_q  <= '0;
            dez_q    <= '0;
            uni_q    <= '0;
        end else begin
            estado_q <= estado_d;
            valor_q  <= valor_d;
            dez_q    <= dez_d;
            uni_q    <= uni_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        valor_d  = valor_q;
        dez_d    = dez_q;
        uni_d    = uni_q;
        soma     = 7'(dez_q) * 7'd10 + 7'(DIG);
        if (CLEAR) begin
            estado_d = IDLE;
            valor_d  = '0;
            dez_d    = '0;
            uni_d    = '0;
        end else if (press) begin
            case (estado_q)
                WAIT_UNI: begin
                    if (DIG > MAX_DIGITO || soma > MAX_VALOR) begin
                        estado_d = ERR;
                    end else begin
                        valor_d  = soma[4:0];
                        uni_d    = DIG;
                        estado_d = DONE;
                    end
                end
                default: begin
                    if (DIG > MAX_DIGITO) begin
                        estado_d = ERR;
                    end else begin
                        dez_d    = DIG;
                        uni_d    = '0;
                        estado_d = WAIT_UNI;
                    end
                end
            endcase
        end
    end

    always_comb begin
        VALID = (estado_q == DONE);
        ERRO  = (estado_q == ERR);
        VALOR = valor_q;
        DEZ   = dez_q;
        UNI   = uni_q;
    end

endmodule

// File: tb/tb_entrada_decimal.sv
// Directed self-checking bench for entrada_decimal; debounce scenarios run when
// ENTRADA_DEBOUNCE_EN is defined (DEB_CYCLES = 8).
module tb_entrada_decimal;

    localparam int DEB = 8;
`ifdef ENTRADA_DEBOUNCE_EN
    localparam int EXTRA = DEB;
`else
    localparam int EXTRA = 0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       RST_N    = 1'b0;
    logic [3:0] DIG      = 4'd0;
    logic       ENTER    = 1'b1;
    logic       CLEAR    = 1'b0;
    logic [4:0] VALOR;
    logic       VALID, ERRO;
    logic [3:0] DEZ, UNI;

    int n_checks = 0;
    int n_fail   = 0;

    entrada_decimal #(.DEB_CYCLES(DEB)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .DIG      (DIG),
        .ENTER    (ENTER),
        .CLEAR    (CLEAR),
        .VALOR    (VALOR),
        .VALID    (VALID),
        .ERRO     (ERRO),
        .DEZ      (DEZ),
        .UNI      (UNI)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [3:0] d);
        DIG   = d;
        ENTER = 1'b0;
        tick(3 + EXTRA);
        ENTER = 1'b1;
        tick(EXTRA + 4);
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        ENTER = 1'b1;
        tick(3);
        n_checks++; if (VALOR !== 5'd0) begin $display("FAIL reset_valor: got %0d expected 0", VALOR); n_fail++; end
        n_checks++; if (VALID !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", VALID); n_fail++; end
        n_checks++; if (ERRO !== 1'b0) begin $display("FAIL reset_erro: got %b expected 0", ERRO); n_fail++; end
        n_checks++; if (DEZ !== 4'd0) begin $display("FAIL reset_dez: got %0d expected 0", DEZ); n_fail++; end
        n_checks++; if (UNI !== 4'd0) begin $display("FAIL reset_uni: got %0d expected 0", UNI); n_fail++; end
        RST_N = 1'b1;
        tick(6 + EXTRA);
    endtask

    task automatic test_valor_27();
        DIG   = 4'd2;
        ENTER = 1'b0;
        tick(2 + EXTRA);
        n_checks++; if (DEZ !== 4'd0) begin $display("FAIL lat_tens_early: got %0d expected 0", DEZ); n_fail++; end
        tick(1);
        n_checks++; if (DEZ !== 4'd2) begin $display("FAIL lat_tens_edge3: got %0d expected 2", DEZ); n_fail++; end
        ENTER = 1'b1;
        tick(EXTRA + 4);
        DIG   = 4'd7;
        ENTER = 1'b0;
        tick(2 + EXTRA);
        n_checks++; if (VALID !== 1'b0) begin $display("FAIL lat_units_early: got %b expected 0", VALID); n_fail++; end
        tick(1);
        n_checks++; if (VALID !== 1'b1) begin $display("FAIL lat_units_edge3: got %b expected 1", VALID); n_fail++; end
        ENTER = 1'b1;
        tick(EXTRA + 4);
        n_checks++; if (VALOR !== 5'd27) begin $display("FAIL v27_valor: got %0d expected 27", VALOR); n_fail++; end
        n_checks++; if (DEZ !== 4'd2) begin $display("FAIL v27_dez: got %0d expected 2", DEZ); n_fail++; end
        n_checks++; if (UNI !== 4'd7) begin $display("FAIL v27_uni: got %0d expected 7", UNI); n_fail++; end
        n_checks++; if (ERRO !== 1'b0) begin $display("FAIL v27_erro: got %b expected 0", ERRO); n_fail++; end
    endtask

    task automatic test_overflow();
        press(4'd3);
        n_checks++; if (VALID !== 1'b0) begin $display("FAIL ovf_tens_valid: got %b expected 0", VALID); n_fail++; end
        n_checks++; if (UNI !== 4'd0) begin $display("FAIL ovf_tens_uni: got %0d expected 0", UNI); n_fail++; end
        press(4'd5);
        n_checks++; if (ERRO !== 1'b1) begin $display("FAIL ovf_erro: got %b expected 1", ERRO); n_fail++; end
        n_checks++; if (VALID !== 1'b0) begin $display("FAIL ovf_valid: got %b expected 0", VALID); n_fail++; end
        n_checks++; if (VALOR !== 5'd27) begin $display("FAIL ovf_valor_hold: got %0d expected 27", VALOR); n_fail++; end
        press(4'd1);
        n_checks++; if (ERRO !== 1'b0) begin $display("FAIL ovf_recover_erro: got %b expected 0", ERRO); n_fail++; end
        press(4'd0);
        n_checks++; if (VALOR !== 5'd10) begin $display("FAIL v10_valor: got %0d expected 10", VALOR); n_fail++; end
        n_checks++; if (VALID !== 1'b1) begin $display("FAIL v10_valid: got %b expected 1", VALID); n_fail++; end
        n_checks++; if (UNI !== 4'd0 || DEZ !== 4'd1) begin $display("FAIL v10_digits: got dez=%0d uni=%0d expected 1/0", DEZ, UNI); n_fail++; end
    endtask

    task automatic test_clear_priority();
        press(4'd4);
        n_checks++; if (DEZ !== 4'd4 || VALOR !== 5'd10) begin $display("FAIL clr_setup: got dez=%0d valor=%0d expected 4/10", DEZ, VALOR); n_fail++; end
        DIG   = 4'd2;
        ENTER = 1'b0;
        tick(2 + EXTRA);
        CLEAR = 1'b1;
        tick(1);
        CLEAR = 1'b0;
        n_checks++; if (VALOR !== 5'd0) begin $display("FAIL clr_valor: got %0d expected 0", VALOR); n_fail++; end
        n_checks++; if (VALID !== 1'b0 || ERRO !== 1'b0) begin $display("FAIL clr_flags: got valid=%b erro=%b expected 0/0", VALID, ERRO); n_fail++; end
        n_checks++; if (DEZ !== 4'd0 || UNI !== 4'd0) begin $display("FAIL clr_digits: got dez=%0d uni=%0d expected 0/0", DEZ, UNI); n_fail++; end
        ENTER = 1'b1;
        tick(EXTRA + 4);
        press(4'd2);
        n_checks++; if (DEZ !== 4'd2 || VALID !== 1'b0) begin $display("FAIL clr_idle_after: got dez=%0d valid=%b expected 2/0", DEZ, VALID); n_fail++; end
    endtask

    task automatic test_bad_digit();
        pulse_clear();
        press(4'd12);
        n_checks++; if (ERRO !== 1'b1) begin $display("FAIL bad_idle_erro: got %b expected 1", ERRO); n_fail++; end
        press(4'd4);
        n_checks++; if (ERRO !== 1'b0 || DEZ !== 4'd4) begin $display("FAIL bad_tens_ok: got erro=%b dez=%0d expected 0/4", ERRO, DEZ); n_fail++; end
        press(4'd11);
        n_checks++; if (ERRO !== 1'b1 || VALID !== 1'b0) begin $display("FAIL bad_units_erro: got erro=%b valid=%b expected 1/0", ERRO, VALID); n_fail++; end
    endtask

    task automatic test_reset_mid_entry();
        pulse_clear();
        press(4'd3);
        RST_N = 1'b0;
        tick(1);
        n_checks++; if (DEZ !== 4'd0) begin $display("FAIL rst_mid_dez: got %0d expected 0", DEZ); n_fail++; end
        RST_N = 1'b1;
        tick(6 + EXTRA);
        press(4'd1);
        n_checks++; if (DEZ !== 4'd1 || VALID !== 1'b0) begin $display("FAIL rst_mid_fresh: got dez=%0d valid=%b expected 1/0", DEZ, VALID); n_fail++; end
        press(4'd5);
        n_checks++; if (VALOR !== 5'd15 || VALID !== 1'b1) begin $display("FAIL rst_mid_v15: got valor=%0d valid=%b expected 15/1", VALOR, VALID); n_fail++; end
    endtask

    task automatic test_reset_hold_enter();
        RST_N = 1'b0;
        ENTER = 1'b0;
        DIG   = 4'd5;
        tick(3);
        RST_N = 1'b1;
        tick(20 + 3 * EXTRA);
        n_checks++; if (DEZ !== 4'd0 || ERRO !== 1'b0) begin $display("FAIL hold_rst_nopress: got dez=%0d erro=%b expected 0/0", DEZ, ERRO); n_fail++; end
        ENTER = 1'b1;
        tick(EXTRA + 6);
        n_checks++; if (DEZ !== 4'd0) begin $display("FAIL hold_rst_release: got dez=%0d expected 0", DEZ); n_fail++; end
        press(4'd5);
        n_checks++; if (DEZ !== 4'd5) begin $display("FAIL hold_rst_rearm: got dez=%0d expected 5", DEZ); n_fail++; end
    endtask

`ifdef ENTRADA_DEBOUNCE_EN
    task automatic test_debounce();
        pulse_clear();
        DIG   = 4'd1;
        ENTER = 1'b0;
        tick(5);
        ENTER = 1'b1;
        tick(20);
        n_checks++; if (DEZ !== 4'd0 || VALID !== 1'b0) begin $display("FAIL deb_glitch: got dez=%0d valid=%b expected 0/0", DEZ, VALID); n_fail++; end
        ENTER = 1'b0;
        tick(20);
        ENTER = 1'b1;
        tick(20);
        n_checks++; if (DEZ !== 4'd1 || VALID !== 1'b0) begin $display("FAIL deb_one_press: got dez=%0d valid=%b expected 1/0", DEZ, VALID); n_fail++; end
        pulse_clear();
        ENTER = 1'b0;
        tick(1000);
        ENTER = 1'b1;
        tick(20);
        n_checks++; if (DEZ !== 4'd1 || VALID !== 1'b0) begin $display("FAIL deb_long_hold: got dez=%0d valid=%b expected 1/0", DEZ, VALID); n_fail++; end
    endtask
`endif

    initial begin
        tick(1);
        test_reset();
        test_valor_27();
        test_overflow();
        test_clear_priority();
        test_bad_digit();
        test_reset_mid_entry();
        test_reset_hold_enter();
`ifdef ENTRADA_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/entrada_decimal.md
ENTRADA_DECIMAL -- requirements
Module: entrada_decimal

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset; ports CLOCK_50 (clock) and RST_N (reset).
REQ-002 SHALL have parameter DEB_CYCLES, default 50000, setting the debounce stability window in clock cycles (1 ms at 50 MHz).
REQ-003 Port list (name, direction, width, meaning):
- CLOCK_50  in  1  system clock, 50 MHz.
- RST_N  in  1  synchronous reset, active-low.
- DIG  in  4  decimal digit from SW[3:0].
- ENTER  in  1  raw pushbutton, active-low (KEY style), asynchronous to the clock.
- CLEAR  in  1  synchronous abort, active-high.
- VALOR  out  5  binary value entered, 0..31.
- VALID  out  1  VALOR holds a completed, in-range entry.
- ERRO  out  1  last entry was rejected.
- DEZ  out  4  captured tens digit, for the display decoder.
- UNI  out  4  captured units digit, for the display decoder.

Function
REQ-004 SHALL synchronize ENTER through two flip-flops; a press event SHALL be one single-cycle pulse per falling edge of the synchronized, debounced ENTER.
REQ-005 SHALL implement the FSM states IDLE, WAIT_UNI, DONE and ERR.
REQ-006 Press in IDLE, DONE or ERR: if DIG <= 9, SHALL capture DEZ = DIG, clear UNI, VALID and ERRO, and go to WAIT_UNI; if DIG > 9, SHALL go to ERR.
REQ-007 Press in WAIT_UNI: if DIG > 9, SHALL go to ERR; otherwise SHALL compute 10*DEZ + DIG at 7-bit width.
REQ-008 Result <= 31: SHALL register VALOR = result and UNI = DIG, and go to DONE; result > 31: SHALL go to ERR with VALOR unchanged.
REQ-009 VALID SHALL be high exactly while in DONE; ERRO SHALL be high exactly while in ERR; VALOR SHALL hold its value until the next DONE entry, CLEAR or reset.
REQ-010 CLEAR high SHALL force IDLE and zero all outputs on that edge, and SHALL take priority over a simultaneous press.
REQ-011 Holding ENTER low SHALL produce no additional presses.
REQ-012 A bounce shorter than the debounce window SHALL produce no press.
REQ-013 Latency without debounce: the press SHALL update state on the 3rd rising edge after ENTER is first sampled low.
REQ-014 Latency with debounce: the press SHALL update state DEB_CYCLES edges later than without debounce.

Reset
REQ-015 RST_N low at a rising edge SHALL force IDLE, VALOR=0, VALID=0, ERRO=0, DEZ=0 and UNI=0.
REQ-016 Reset SHALL preset the synchronizer and debounce registers to ENTER-released and clear the debounce counter.
REQ-017 Reset mid-entry SHALL discard any captured tens digit.
REQ-018 Holding ENTER low through the release of reset SHALL NOT generate a press.

Configuration
REQ-019 Macro ENTRADA_DEBOUNCE_EN defined: the synchronized ENTER SHALL be accepted only after DEB_CYCLES consecutive cycles at the same level (saturating counter, reloaded on any change).
REQ-020 Macro ENTRADA_DEBOUNCE_EN undefined: the synchronized ENTER SHALL feed edge detection directly, no counter SHALL be synthesized, and DEB_CYCLES SHALL be ignored.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding, MAX_VALOR = 31 and MAX_DIGITO = 9.
REQ-022 Synchronizer, optional debounce and falling-edge detection SHALL live in sub-module detector_borda (inputs CLOCK_50, RST_N, raw in; output press pulse).

Verification
REQ-023 Bench SHALL cover, without debounce: reset; DIG=2 press, DIG=7 press -> VALOR=27, VALID=1, DEZ=2, UNI=7; each press takes effect on the 3rd edge after ENTER is sampled low.
REQ-024 Bench SHALL cover: DIG=3 press, DIG=5 press -> ERR, ERRO=1, VALID=0, VALOR holds its previous value; then DIG=1, DIG=0 -> VALOR=10, VALID=1.
REQ-025 Bench SHALL cover: DIG=12 press in IDLE -> ERR; DIG=4 press in WAIT_UNI with DIG then 11 -> ERR.
REQ-026 Bench SHALL cover: CLEAR asserted in the same cycle as a press in WAIT_UNI -> IDLE with all outputs 0; reset asserted in WAIT_UNI -> tens digit discarded.
REQ-027 Bench SHALL cover, with ENTRADA_DEBOUNCE_EN and DEB_CYCLES=8: a 5-cycle low glitch gives no press; a 20-cycle low gives exactly one press; ENTER held low for 1000 cycles gives exactly one press.
